// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver with 16x oversampling, 3-sample majority
//            voting, framing-error pulse and a first-word-fall-through
//            receive buffer with a sticky overrun flag.
// Config   : UART_RX_FIFO_EN defined   -> FIFO_DEPTH-entry FIFO buffer
//            UART_RX_FIFO_EN undefined -> single holding register
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLOCK_SPEED_HZ = 54_000_000,
    parameter int BAUD_RATE      = 115_200,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_i,
    input  logic                        rd_i,
    input  logic                        clr_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        framing_err_o,
    output logic                        overrun_o
);

    // Oversample divider, rounded to nearest
    localparam int c_DIV = (CLOCK_SPEED_HZ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int c_PW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(c_DIV - 1);
    localparam int c_CW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_PW-1:0] r_presc;
    logic [3:0]      r_tick;
    logic [3:0]      r_bit_cnt;
    logic [1:0]      r_samp;
    logic [7:0]      r_shift;
    logic            r_push;
    logic            r_framing_err;
    logic            r_overrun;

    logic            w_tick;
    logic            w_fall;
    logic            w_maj;
    logic            w_start;
    logic            w_enter_data;
    logic            w_sample_bit;
    logic            w_bit_end;
    logic            w_push_set;
    logic            w_ferr_set;

    assign w_tick = (r_presc == c_PRESC_MAX);
    assign w_fall = r_rx_prev & ~r_rx_sync;
    // Two stored samples (ticks 7 and 8) plus the live line at tick 9
    assign w_maj  = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rx_sync) |
                    (r_samp[0] & r_rx_sync);

    // Line synchronizer and edge history; idle-high after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_fall) w_state_nxt = c_START;
            end
            c_START: begin
                if (w_tick && (r_tick == 4'd7)) begin
                    w_state_nxt = r_rx_sync ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_tick && (r_tick == 4'd15) && (r_bit_cnt == 4'd7)) begin
                    w_state_nxt = c_STOP;
                end
            end
            c_STOP: begin
                if (w_tick && (r_tick == 4'd8)) begin
                    w_state_nxt = w_maj ? c_IDLE : c_WAIT_IDLE;
                end
            end
            c_WAIT_IDLE: begin
                if (r_rx_sync) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs: per-state strobes steering the receive datapath
    always_comb begin
        w_start      = 1'b0;
        w_enter_data = 1'b0;
        w_sample_bit = 1'b0;
        w_bit_end    = 1'b0;
        w_push_set   = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_state)
            c_IDLE:  w_start      = w_fall;
            c_START: w_enter_data = w_tick && (r_tick == 4'd7) && !r_rx_sync;
            c_DATA: begin
                // bit_cnt[3] set marks the second half of the start bit
                w_sample_bit = w_tick && (r_tick == 4'd8) && !r_bit_cnt[3];
                w_bit_end    = w_tick && (r_tick == 4'd15);
            end
            c_STOP: begin
                w_push_set = w_tick && (r_tick == 4'd8) && w_maj;
                w_ferr_set = w_tick && (r_tick == 4'd8) && !w_maj;
            end
            default: ;
        endcase
    end

    // Receive datapath: prescaler, tick/bit counters, sampler, shifter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_tick        <= 4'd0;
            r_bit_cnt     <= 4'd0;
            r_samp        <= 2'b11;
            r_shift       <= 8'h00;
            r_push        <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            if (w_start || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + c_PW'(1);
            end

            if (w_start) begin
                r_tick <= 4'd0;
            end else if (w_tick) begin
                r_tick <= r_tick + 4'd1;
            end

            // Tick counter keeps running into DATA so bit cells stay aligned
            // to the start edge; the leftover start half counts as bit -1.
            if (w_enter_data) begin
                r_bit_cnt <= 4'hF;
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_tick && ((r_tick == 4'd6) || (r_tick == 4'd7))) begin
                r_samp <= {r_samp[0], r_rx_sync};
            end

            if (w_sample_bit) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end

            r_push        <= w_push_set;
            r_framing_err <= w_ferr_set;
        end
    end

    assign framing_err_o = r_framing_err;
    assign overrun_o     = r_overrun;

`ifdef UART_RX_FIFO_EN
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;

    assign w_full = (r_count == c_FULL);
    assign w_pop  = rd_i && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_wr   = r_push && (!w_full || w_pop);

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    // FIFO pointers, fill level and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (r_push && !w_wr) begin
                r_overrun <= 1'b1;
            end else if (clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign valid_o = (r_count != '0);
    assign count_o = r_count;
    assign data_o  = valid_o ? r_mem[r_rd_ptr] : 8'h00;
`else
    logic       r_full;
    logic [7:0] r_hold;
    logic       w_pop;
    logic       w_wr;

    assign w_pop = rd_i && r_full;
    assign w_wr  = r_push && (!r_full || w_pop);

    // Single-byte holding register and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= 1'b0;
            r_hold    <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_hold <= r_shift;
                r_full <= 1'b1;
            end else if (w_pop) begin
                r_full <= 1'b0;
            end
            if (r_push && !w_wr) begin
                r_overrun <= 1'b1;
            end else if (clr_i) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign valid_o = r_full;
    assign count_o = {{(c_CW-1){1'b0}}, r_full};
    assign data_o  = r_full ? r_hold : 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo. A byte-queue
//            model of the receive buffer is compared against the DUT every
//            cycle outside the short window where a byte lands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    // Main DUT: 16 MHz / 115200 -> 16e6/1843200 = 8.68 -> DIV 9
    localparam int DIV_M = 9;
    localparam int BIT_M = 16 * DIV_M;
    // Default DUT: 54 MHz / 115200 -> 29.30 -> DIV 29
    localparam int DIV_D = 29;
    localparam int BIT_D = 16 * DIV_D;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 16;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_i = 1'b1;
    logic       rd_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [4:0] count_o;
    logic       framing_err_o;
    logic       overrun_o;

    logic       rx_d = 1'b1;
    logic       rd_d = 1'b0;
    logic       clr_d = 1'b0;
    logic [7:0] data_d;
    logic       valid_d;
    logic [4:0] count_d;
    logic       ferr_d;
    logic       ovr_d;

    int         total = 0;
    int         bad = 0;
    logic       chk_en = 1'b0;
    logic       blind = 1'b0;
    int         ferr_cnt = 0;
    logic [7:0] mq[$];
    logic       m_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLOCK_SPEED_HZ(16_000_000),
        .BAUD_RATE     (115_200),
        .FIFO_DEPTH    (16)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .rd_i         (rd_i),
        .clr_i        (clr_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .count_o      (count_o),
        .framing_err_o(framing_err_o),
        .overrun_o    (overrun_o)
    );

    uart_rx_fifo u_dut_def (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_d),
        .rd_i         (rd_d),
        .clr_i        (clr_d),
        .data_o       (data_d),
        .valid_o      (valid_d),
        .count_o      (count_d),
        .framing_err_o(ferr_d),
        .overrun_o    (ovr_d)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mpush(input logic [7:0] b);
        if (mq.size() < CAP) mq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    // Called at a negedge; pops at the following posedge
    task automatic do_read();
        rd_i = 1'b1;
        @(posedge clk);
        #1;
        if (mq.size() > 0) void'(mq.pop_front());
        @(negedge clk);
        rd_i = 1'b0;
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        m_ovr = 1'b0;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovr = 1'b0;
        check("rst_data",  int'(data_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_count", int'(count_o), 0);
        check("rst_ferr",  int'(framing_err_o), 0);
        check("rst_ovr",   int'(overrun_o), 0);
        wait_cyc(3);
        rst_n = 1'b1;
    endtask

    // One 8N1 frame on the main DUT; rst_bit >= 0 pulses reset mid-bit
    task automatic send(input logic [7:0] b, input logic stop, input int rst_bit);
        rx_i = 1'b0;
        wait_cyc(BIT_M);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            if (i == rst_bit) begin
                wait_cyc(BIT_M / 2);
                do_reset();
                wait_cyc(BIT_M - BIT_M / 2 - 3);
            end else begin
                wait_cyc(BIT_M);
            end
        end
        rx_i = stop;
        if (rst_bit >= 0) begin
            wait_cyc(BIT_M + BIT_M / 2);
        end else begin
            // Byte lands around tick 9 of the stop bit
            wait_cyc(9 * DIV_M - 8);
            blind = 1'b1;
            wait_cyc(24);
            if (stop) mpush(b);
            check("ferr_pulse_cycles", ferr_cnt, stop ? 0 : 1);
            blind = 1'b0;
            wait_cyc(7 * DIV_M - 16);
            rx_i = 1'b1;
            wait_cyc(stop ? BIT_M / 2 : BIT_M);
        end
    endtask

    task automatic send_def(input logic [7:0] b);
        rx_d = 1'b0;
        wait_cyc(BIT_D);
        for (int i = 0; i < 8; i++) begin
            rx_d = b[i];
            wait_cyc(BIT_D);
        end
        rx_d = 1'b1;
        wait_cyc(9 * DIV_D - 8);
        check("def_valid_early", int'(valid_d), 0);
        wait_cyc(24);
        check("def_valid", int'(valid_d), 1);
        check("def_data",  int'(data_d), 8'h55);
        check("def_count", int'(count_d), 1);
        wait_cyc(BIT_D);
        rd_d = 1'b1;
        wait_cyc(1);
        rd_d = 1'b0;
        check("def_valid_after_rd", int'(valid_d), 0);
        check("def_ovr", int'(ovr_d), 0);
        check("def_ferr", int'(ferr_d), 0);
    endtask

    // Compare process: DUT buffer state against the byte-queue model
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            if (blind) begin
                if (framing_err_o) ferr_cnt++;
            end else begin
                ferr_cnt = 0;
                check("valid", int'(valid_o), int'(mq.size() > 0));
                check("count", int'(count_o), mq.size());
                if (mq.size() > 0) check("data", int'(data_o), int'(mq[0]));
                check("overrun", int'(overrun_o), int'(m_ovr));
                check("framing_err", int'(framing_err_o), 0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        wait_cyc(4);

        // Read while empty is ignored
        do_read();
        wait_cyc(2);

        // 0x55 with default parameters on the second instance
        send_def(8'h55);

        // 0x55 on the main instance, then pop
        send(8'h55, 1'b1, -1);
        check("b55_valid", int'(valid_o), 1);
        check("b55_data",  int'(data_o), 8'h55);
        check("b55_count", int'(count_o), 1);
        do_read();
        check("b55_valid_after_rd", int'(valid_o), 0);

        // 4-tick glitch: false start, receiver must still take a real frame
        rx_i = 1'b0;
        wait_cyc(4 * DIV_M);
        rx_i = 1'b1;
        wait_cyc(2 * BIT_M);
        check("glitch_count", int'(count_o), 0);
        send(8'h5A, 1'b1, -1);
        check("after_glitch_data", int'(data_o), 8'h5A);
        do_read();

        // Bad stop bit, then a good frame
        send(8'hA5, 1'b0, -1);
        check("ferr_count", int'(count_o), 0);
        send(8'h3C, 1'b1, -1);
        check("after_ferr_data", int'(data_o), 8'h3C);
        do_read();

        // 17 unread bytes overflow the buffer
        for (int i = 0; i < 17; i++) send(8'(i), 1'b1, -1);
        check("full_count", int'(count_o), CAP);
        check("full_ovr", int'(overrun_o), 1);
        for (int i = 0; i < CAP; i++) begin
            check("drain_data", int'(data_o), i);
            do_read();
        end
        check("drained_valid", int'(valid_o), 0);
        check("ovr_still_set", int'(overrun_o), 1);
        do_clr();
        check("ovr_cleared", int'(overrun_o), 0);

        // Reset during bit 4 of 0xFF with a byte already buffered
        send(8'h42, 1'b1, -1);
        send(8'hFF, 1'b1, 4);
        check("post_rst_count", int'(count_o), 0);
        send(8'h81, 1'b1, -1);
        check("post_rst_data", int'(data_o), 8'h81);
        check("post_rst_cnt1", int'(count_o), 1);
        do_read();

        // Two unread bytes: holding register overruns, FIFO keeps both
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        check("two_data",  int'(data_o), 8'h11);
        check("two_ovr",   int'(overrun_o), (CAP == 1) ? 1 : 0);
        check("two_count", int'(count_o), (CAP == 1) ? 1 : 2);
        wait_cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_SPEED_HZ, default 54_000_000, meaning the frequency of clk in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial line rate in bits per second.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the receive FIFO depth in bytes; it SHALL be a power of two from 2 to 256.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_i, input, 1 bit: serial 8N1 line, asynchronous to clk, idle high.
REQ-007 SHALL have port rd_i, input, 1 bit: pop the head byte.
REQ-008 SHALL have port clr_i, input, 1 bit: clear the sticky overrun flag.
REQ-009 SHALL have port data_o, output, 8 bits: FIFO head byte, first-word-fall-through.
REQ-010 SHALL have port valid_o, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port count_o, output, $clog2(FIFO_DEPTH)+1 bits: FIFO fill level.
REQ-012 SHALL have port framing_err_o, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun_o, output, 1 bit: sticky flag set when a byte is dropped.

Function
REQ-014 SHALL pass rx_i through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-015 SHALL generate a 16x oversample tick every DIV clk cycles, where DIV = round(CLOCK_SPEED_HZ/(16*BAUD_RATE)); default DIV = 29.
- The prescaler SHALL restart at 0 on start-edge detection.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: a synchronized 1->0 transition SHALL move the FSM to START.
REQ-018 START: at tick 8, line 0 SHALL move to DATA; line 1 is a false start and SHALL return to IDLE with no output.
REQ-019 DATA: SHALL receive 8 bits LSB first, 16 ticks per bit; each bit SHALL be the majority of the samples at ticks 7, 8 and 9.
REQ-020 STOP: a stop-bit majority of 1 SHALL push the byte into the FIFO on the next clk and return the FSM to IDLE.
REQ-021 STOP: a stop-bit majority of 0 SHALL discard the byte, pulse framing_err_o high for exactly one cycle and enter WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL stay until the synchronized line is 1, then go to IDLE; break conditions therefore yield one error only.
REQ-023 valid_o SHALL assert 1 cycle after the push.
REQ-024 rd_i with valid_o=1 SHALL advance the head at the next edge; rd_i while empty SHALL be ignored.
REQ-025 A push while full without rd_i in the same cycle SHALL drop the new byte and set overrun_o; FIFO contents stay unchanged.
REQ-026 A push while full with rd_i in the same cycle SHALL be accepted, with count unchanged and no overrun.
REQ-027 A simultaneous push and pop at any level SHALL leave count_o unchanged.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 count_o SHALL never exceed FIFO_DEPTH.
REQ-030 clr_i SHALL clear overrun_o next cycle; a same-cycle set SHALL win over clr_i.

Reset
REQ-031 rst_n low SHALL immediately force: FSM to IDLE, prescaler and bit counters to 0, FIFO empty.
- Outputs SHALL reset to data_o=0x00, valid_o=0, count_o=0, framing_err_o=0, overrun_o=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial byte; after release, reception SHALL start only on a new falling edge.

Configuration
REQ-033 Macro UART_RX_FIFO_EN SHALL control the receive buffer.
- Defined: the FIFO per REQ-003..REQ-030 SHALL be used.
- Undefined: FIFO_DEPTH SHALL be ignored and a single holding register used; count_o is 0 or 1; a push while holding without same-cycle rd_i SHALL drop the new byte and set overrun_o.

Verification
REQ-034 Bench SHALL cover: 0x55 at 115200 baud with defaults -> valid_o=1, data_o=0x55, count_o=1 about 9.5 bit times after the start edge; rd_i -> valid_o=0.
REQ-035 Bench SHALL cover: 4-tick low glitch on idle line -> no push, FSM back in IDLE, framing_err_o stays 0.
REQ-036 Bench SHALL cover: 0xA5 sent with stop bit 0 -> one framing_err_o pulse, count_o=0; a following 0x3C is received correctly.
REQ-037 Bench SHALL cover: bytes 0x00..0x10 (17) with no reads -> count_o=16, overrun_o=1, reads return 0x00..0x0F; clr_i clears overrun_o.
REQ-038 Bench SHALL cover: rst_n pulsed during bit 4 of 0xFF -> all outputs at reset values; next frame 0x81 is received intact.
REQ-039 Bench SHALL cover: UART_RX_FIFO_EN undefined, 0x11 then 0x22 sent unread -> data_o=0x11, overrun_o=1, count_o=1.
